// File: rtl/toggle_hs_pkg.sv
// Shared definitions for the toggle-encoded event link: FSM encoding and
// the default synchroniser depth.
`timescale 1ns/1ps
package toggle_hs_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_VALID = 1'b1
   } state_t;

   localparam int SYNC_STAGES_DEF = 2;

endpackage

// File: rtl/sync_chain.sv
// N-flop level synchroniser for a signal asynchronous to clk; all flops
// clear to 0 on reset so both link ends start from level 0.
`timescale 1ns/1ps
module sync_chain
   import toggle_hs_pkg::*;
#(
   parameter int STAGES = SYNC_STAGES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] ff;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) ff <= '0;
      else       ff <= {ff[STAGES-2:0], d};
   end

   assign q = ff[STAGES-1];

endmodule

// File: rtl/toggle_event_decoder.sv
// Receive end of the toggle event link: synchronise t_in, turn each level
// change into one valid/ready event, return a toggle acknowledge.
`timescale 1ns/1ps
module toggle_event_decoder
   import toggle_hs_pkg::*;
#(
   parameter int SYNC_STAGES = SYNC_STAGES_DEF,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             t_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             ack_t,
   output logic [CNT_W-1:0] evt_count,
   output logic             overflow,
   input  logic             ovf_clr
);

   state_t state, state_nxt;
   logic   t_sync, t_d;
   logic   evt_edge, hs, ovf_set;

   sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (t_in),
      .q     (t_sync)
   );

   assign evt_edge  = t_sync ^ t_d;
   assign evt_valid = (state == ST_VALID);
   assign hs        = evt_valid & evt_ready;
   // A new edge during a handshake replaces the accepted event, so it is not an overflow.
   assign ovf_set   = evt_valid & evt_edge & ~hs;

   // NOTE: next state gets a default before the case so no latch is inferred.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (evt_edge)             state_nxt = ST_VALID;
         ST_VALID: if (hs && !evt_edge)      state_nxt = ST_IDLE;
         default:                            state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_IDLE;
         t_d       <= 1'b0;
         ack_t     <= 1'b0;
         evt_count <= '0;
         overflow  <= 1'b0;
      end else begin
         state <= state_nxt;
         t_d   <= t_sync;
         if (hs) begin
            ack_t     <= ~ack_t;
            evt_count <= evt_count + CNT_W'(1);
         end
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule
